asps_ir_stimulus_gen: RTL
=========================

Name: asps_ir_stimulus_gen

Overview:
Car-traffic initiator for the smart parking system. It accepts queued entry/exit requests (direction plus 2-bit car ID) and drives the active-low IR_entry/IR_exit sensor lines and the id bus, with controlled pulse width, ID setup/hold and an inter-event gap. It plays the sensor/car side of the interface that the parking controller's entry/exit detector and timestamp buffer consume. It is used as a synthesizable traffic source in system benches and on FPGA demos.

Parameters:
PULSE_CYCLES, 4, cycles the selected IR line is held low per event (1..255)
ID_HOLD, 2, cycles id is stable before IR falls and after IR rises (1..255)
GAP_CYCLES, 2, minimum idle cycles after ID hold before the next event (1..255)
FIFO_DEPTH, 4, request queue depth (power of two, 2..16)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  queue can accept a request
req_dir  input  1  0 = entry event, 1 = exit event
req_id  input  2  car ID for the event
IR_entry  output  1  entry sensor line, 0 = car present
IR_exit  output  1  exit sensor line, 0 = car present
id  output  2  car ID bus to the parking controller
busy  output  1  FSM not in IDLE
event_done  output  1  one-cycle pulse when the IR line returns high
event_dir  output  1  direction of the event flagged by event_done
pending  output  5  number of queued requests, excluding the one in flight

Behaviour:
- One clock, clk. reset is synchronous and active-high. All outputs are registered.
- Reset values:
  - IR_entry = 1, IR_exit = 1, id = 0
  - busy = 0, event_done = 0, event_dir = 0
  - pending = 0, req_ready = 1
  - FSM = IDLE, FIFO flushed
- Queue:
  - A push occurs on a clock edge where req_valid && req_ready.
  - req_ready = (pending != FIFO_DEPTH), computed from the registered count only. There is no bypass: a push while full is refused, even if a pop happens in the same cycle.
  - On a simultaneous push and pop, pending is unchanged.
  - Requests are issued strictly in FIFO order.
- FSM states and transitions:
  - IDLE: if pending > 0, pop, latch dir and id, drive id = popped id, go to SETUP.
  - SETUP (ID_HOLD cycles): id stable, both IR lines 1. Then go to ACTIVE.
  - ACTIVE (PULSE_CYCLES cycles): drive IR_entry = 0 if dir = 0, else IR_exit = 0. The other line stays 1. Then go to HOLD.
  - On the ACTIVE -> HOLD edge: IR line returns to 1, event_done = 1 for exactly one cycle, event_dir = dir.
  - HOLD (ID_HOLD cycles): id still stable. Then go to GAP and set id = 0.
  - GAP (GAP_CYCLES cycles): both IR lines 1, id = 0. Then go to IDLE.
- Invariants:
  - IR_entry and IR_exit are never both 0.
  - id never changes while any IR line is 0.
- Timing, for a request accepted at edge T with the FSM in IDLE:
  - pop, SETUP and id valid at edge T+1
  - IR low from edge T+1+ID_HOLD
  - IR high and event_done at edge T+1+ID_HOLD+PULSE_CYCLES
- Event period:
  - Back-to-back events start every 1+ID_HOLD+PULSE_CYCLES+ID_HOLD+GAP_CYCLES cycles (11 at defaults).
  - The IR line is high for ≥ 2·ID_HOLD+GAP_CYCLES+1 cycles between pulses.
- State counter: a single 8-bit down-counter, reloaded on each state entry.
- busy = 1 in every state except IDLE.
- Reset mid-operation:
  - Reset in any state returns all outputs to reset values on that edge and flushes the FIFO.
  - No event_done is produced for an interrupted event.
  - A request presented in the reset cycle is dropped.

Test Plan:
- Reset: assert reset 2 cycles -> IR_entry=1, IR_exit=1, id=0, busy=0, pending=0, req_ready=1.
- Single entry, dir=0, id=2, accepted at edge 0 (defaults):
  - id=2 from edge 1 to edge 9
  - IR_entry=0 from edge 3 to edge 7
  - event_done=1 and event_dir=0 after edge 7
  - IR_exit stays 1 throughout
  - id=0 after edge 9
  - busy=0 after edge 11
- Single exit, id=1 -> IR_exit low for exactly 4 cycles, IR_entry stays 1, id=1 stable 2 cycles before and after the pulse, event_dir=1.
- Queue fill with FSM busy on a prior event:
  - push 4 requests -> pending=4, req_ready=0
  - 5th req_valid is held and not accepted until the next pop
  - all events emerge in push order, falling edges exactly 11 cycles apart
- Simultaneous push/pop at pending=2 -> pending stays 2. Push presented when pending=4 with a pop in the same cycle -> refused.
- Reset asserted 2 cycles into ACTIVE with pending=3 -> IR line back to 1 after the reset edge, pending=0, no event_done. The next request after reset produces a normal full event.

Source files
------------

// File: rtl/asps_ir_stimulus_gen.sv
// Car-traffic source for the parking controller: queues entry/exit requests and
// plays them out as active-low IR pulses with ID setup/hold and an inter-event gap.
module asps_ir_stimulus_gen #(
    parameter int PULSE_CYCLES = 4,
    parameter int ID_HOLD      = 2,
    parameter int GAP_CYCLES   = 2,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_dir,
    input  logic [1:0] req_id,
    output logic       IR_entry,
    output logic       IR_exit,
    output logic [1:0] id,
    output logic       busy,
    output logic       event_done,
    output logic       event_dir,
    output logic [4:0] pending
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef struct packed {
        logic       dir;
        logic [1:0] id;
    } req_t;

    typedef enum logic [2:0] {IDLE, SETUP, ACTIVE, HOLD, GAP} state_t;

    req_t          fifo_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [4:0]    count;
    logic          push, pop;

    state_t     state, state_d;
    logic [7:0] cnt, cnt_d;
    req_t       cur, cur_d;
    logic       ir_entry_d, ir_exit_d, event_done_d, event_dir_d, busy_d;
    logic [1:0] id_d;

    // Ready comes from the registered count only, so a full queue refuses a
    // push even when the FSM pops in the same cycle.
    assign req_ready = (count != 5'(FIFO_DEPTH));
    assign pending   = count;
    assign push      = req_valid && req_ready;
    assign pop       = (state == IDLE) && (count != 5'd0);

    always_ff @(posedge clk) begin
        if (push)
            fifo_q[wr_ptr] <= '{dir: req_dir, id: req_id};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 5'd1;
                2'b01:   count <= count - 5'd1;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        cur_d        = cur;
        id_d         = id;
        ir_entry_d   = 1'b1;
        ir_exit_d    = 1'b1;
        event_done_d = 1'b0;
        event_dir_d  = event_dir;
        case (state)
            IDLE: begin
                if (count != 5'd0) begin
                    cur_d   = fifo_q[rd_ptr];
                    id_d    = fifo_q[rd_ptr].id;
                    cnt_d   = 8'(ID_HOLD - 1);
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (cnt == 8'd0) begin
                    cnt_d      = 8'(PULSE_CYCLES - 1);
                    ir_entry_d = cur.dir;
                    ir_exit_d  = ~cur.dir;
                    state_d    = ACTIVE;
                end else begin
                    cnt_d = cnt - 8'd1;
                end
            end
            ACTIVE: begin
                if (cnt == 8'd0) begin
                    cnt_d        = 8'(ID_HOLD - 1);
                    event_done_d = 1'b1;
                    event_dir_d  = cur.dir;
                    state_d      = HOLD;
                end else begin
                    cnt_d      = cnt - 8'd1;
                    ir_entry_d = cur.dir;
                    ir_exit_d  = ~cur.dir;
                end
            end
            HOLD: begin
                if (cnt == 8'd0) begin
                    cnt_d   = 8'(GAP_CYCLES - 1);
                    id_d    = 2'd0;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt - 8'd1;
                end
            end
            GAP: begin
                if (cnt == 8'd0) state_d = IDLE;
                else             cnt_d   = cnt - 8'd1;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            cur        <= '0;
            id         <= '0;
            IR_entry   <= 1'b1;
            IR_exit    <= 1'b1;
            event_done <= 1'b0;
            event_dir  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            cur        <= cur_d;
            id         <= id_d;
            IR_entry   <= ir_entry_d;
            IR_exit    <= ir_exit_d;
            event_done <= event_done_d;
            event_dir  <= event_dir_d;
            busy       <= busy_d;
        end
    end
endmodule
